// File: rtl/icache_nway_pkg.sv
// Shared types and address-field helpers for the set-associative icache.
package icache_nway_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {IDLE, FILL} istate_t;

  // Width of a select signal for n items; a single item still gets one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int words);
    return 30 - off_w(words) - idx_w(sets);
  endfunction
endpackage

// File: rtl/icache_nway_if.sv
// Fetch-side and memory-side bus of the icache; slave is the cache view.
interface icache_nway_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  modport slave  (input imemREN, imemaddr, iload, iwait,
                  output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, iload, iwait,
                  input ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_way.sv
// One way of the icache: valid bits (reset), tag and data arrays (not reset).
module icache_way
  import icache_nway_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WORDS = 2,
  parameter int IDX_W = 3,
  parameter int TAG_W = 26,
  parameter int SEL_W = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  input  logic [SEL_W-1:0] wsel,
  input  logic             we,
  input  logic             tag_we,
  input  logic             vset,
  input  logic             clr,
  input  word_t            wdata,
  output logic             hit,
  output word_t            rdata
);
  logic [SETS-1:0] valid;
  logic [TAG_W-1:0] tags [SETS];
  word_t            data [SETS][WORDS];

  // Flush wins over a line completing in the same cycle.
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST)       valid <= '0;
    else if (clr)    valid <= '0;
    else if (tag_we) valid[idx] <= vset;

  always_ff @(posedge CLK) begin
    if (we)     data[idx][wsel] <= wdata;
    if (tag_we) tags[idx] <= tag;
  end

  assign hit   = valid[idx] && (tags[idx] == tag);
  assign rdata = data[idx][wsel];
endmodule

// File: rtl/icache_nway.sv
// Set-associative icache, round-robin replacement, multi-word block fill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_nway
  import icache_nway_pkg::*;
#(
  parameter int    SETS  = 8,
  parameter int    WAYS  = 2,
  parameter int    WORDS = 2,
  parameter word_t BAD   = 32'hBAD1BAD1
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         flush,
  icache_nway_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);
  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(SETS, WORDS);
  localparam int SEL_W = sel_w(WORDS);
  localparam int VW    = sel_w(WAYS);
  localparam int LO    = 2 + OFF_W;

  istate_t               state, nstate;
  logic [SEL_W-1:0]      cnt, ncnt;
  logic [31-LO:0]        blk, nblk;
  logic [VW-1:0]         victim, nvictim;
  logic                  fpend, nfpend;
  logic [SETS-1:0][VW-1:0] vptr;

  logic [31-LO:0]    cur_blk, act_blk;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [SEL_W-1:0]  rsel;
  logic [WAYS-1:0]   way_hit;
  word_t [WAYS-1:0]  way_rd;
  word_t             hit_data;
  logic              hit, miss, fill_we, last, last_we;
  logic              unused;

  assign unused  = ^bus.imemaddr[1:0];
  assign cur_blk = bus.imemaddr[31:LO];
  // During a fill the arrays follow the latched block, not the fetch address.
  assign act_blk = (state == FILL) ? blk : cur_blk;
  assign idx     = act_blk[IDX_W-1:0];
  assign tag     = act_blk[31-LO:IDX_W];
  assign rsel    = (state == FILL) ? cnt :
                   ((WORDS > 1) ? bus.imemaddr[2 +: SEL_W] : '0);

  assign fill_we = (state == FILL) && !bus.iwait;
  assign last    = (cnt == SEL_W'(WORDS - 1));
  assign last_we = fill_we && last;
  assign hit     = (state == IDLE) && bus.imemREN && (|way_hit) && !flush;
  assign miss    = (state == IDLE) && bus.imemREN && !(|way_hit) && !flush;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(.SETS(SETS), .WORDS(WORDS), .IDX_W(IDX_W), .TAG_W(TAG_W),
                 .SEL_W(SEL_W)) u_way (
      .CLK(CLK), .nRST(nRST), .idx(idx), .tag(tag), .wsel(rsel),
      .we(fill_we && (victim == VW'(w))),
      .tag_we(last_we && (victim == VW'(w))),
      .vset(~(fpend | flush)), .clr(flush), .wdata(bus.iload),
      .hit(way_hit[w]), .rdata(way_rd[w])
    );
  end

  always_comb begin
    hit_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_data = hit_data | way_rd[w];
  end

  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      state <= IDLE; cnt <= '0; blk <= '0; victim <= '0; fpend <= 1'b0;
    end else begin
      state <= nstate; cnt <= ncnt; blk <= nblk; victim <= nvictim; fpend <= nfpend;
    end

  always_ff @(posedge CLK, negedge nRST)
    if (!nRST)        vptr <= '0;
    else if (last_we) vptr[blk[IDX_W-1:0]] <= (WAYS == 1) ? '0 : VW'(victim + 1'b1);

  always_comb begin
    nstate = state; ncnt = cnt; nblk = blk; nvictim = victim; nfpend = fpend;
    bus.ihit = 1'b0; bus.imemload = BAD; bus.iREN = 1'b0; bus.iaddr = '0;
    case (state)
      IDLE:
        if (hit) begin
          bus.ihit = 1'b1; bus.imemload = hit_data;
        end else if (miss) begin
          nstate = FILL; ncnt = '0; nblk = cur_blk;
          nvictim = vptr[cur_blk[IDX_W-1:0]];
        end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {blk, {LO{1'b0}}} + 32'({cnt, 2'b00});
        if (flush) nfpend = 1'b1;
        if (fill_we) begin
          ncnt = cnt + 1'b1;
          if (last) begin nstate = IDLE; nfpend = 1'b0; end
        end
      end
      default: nstate = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      hit_count <= '0; miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
`endif
endmodule
